// File: rtl/mul_stage_pkg.sv
// Shared definitions for the multiplier issue/capture stage: data width,
// FSM state encoding and settle-counter sizing.
package mul_stage_pkg;

  localparam int MUL_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } mul_state_e;

  function automatic int cnt_width(input int settle_cycles);
    return $clog2(settle_cycles + 1);
  endfunction

endpackage

// File: rtl/mul_op_fifo.sv
// Synchronous DEPTH x W operand FIFO; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module mul_op_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/mul_issue_stage.sv
// Registered issue/capture stage around the combinational b_mul multiplier.
// Optional feature: define MUL_ZERO_BYPASS_EN to skip the settle window for zero operands.
//
// state  | meaning
// IDLE   | no operation in flight, waiting for a FIFO entry
// SETTLE | operands and mul_en held stable while b_mul settles
// HOLD   | captured product presented, waiting for out_ready
module mul_issue_stage
  import mul_stage_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DEPTH         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MUL_W-1:0] in_a,
  input  logic [MUL_W-1:0] in_b,
  output logic [MUL_W-1:0] mul_a,
  output logic [MUL_W-1:0] mul_b,
  output logic             mul_en,
  input  logic [MUL_W-1:0] mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MUL_W-1:0] out_result,
  output logic             busy
);

  localparam int CW = cnt_width(SETTLE_CYCLES);

  mul_state_e          state;
  logic [CW-1:0]       cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                launch;
  logic                zero_op;
  logic [2*MUL_W-1:0]  head;
  logic [MUL_W-1:0]    head_a;
  logic [MUL_W-1:0]    head_b;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign head_a   = head[2*MUL_W-1:MUL_W];
  assign head_b   = head[MUL_W-1:0];
  assign launch   = !fifo_empty && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign busy     = !fifo_empty || (state != IDLE);

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (head_a == '0) || (head_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  mul_op_fifo #(
    .DEPTH (DEPTH),
    .W     (2*MUL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (launch),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_en     <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == CW'(1)) begin
            out_result <= mul_result;
            out_valid  <= 1'b1;
            mul_en     <= 1'b0;
            state      <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A pop overrides the HOLD->IDLE exit above so pairs issue back-to-back.
      if (launch) begin
        if (zero_op) begin
          out_result <= '0;
          out_valid  <= 1'b1;
          state      <= HOLD;
        end else begin
          mul_a  <= head_a;
          mul_b  <= head_b;
          mul_en <= 1'b1;
          cnt    <= CW'(SETTLE_CYCLES);
          state  <= SETTLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_stage.sv
// Directed self-checking bench for mul_issue_stage with a behavioural b_mul.
module tb_mul_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_en;
  logic [31:0] mul_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mul_result = mul_en ? (mul_a * mul_b) : 32'h0;

  mul_issue_stage #(.SETTLE_CYCLES(2), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en     (mul_en),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " in_ready"},   32'(in_ready),   32'd1);
    check({tag, " mul_a"},      mul_a,           32'd0);
    check({tag, " mul_b"},      mul_b,           32'd0);
    check({tag, " mul_en"},     32'(mul_en),     32'd0);
    check({tag, " out_valid"},  32'(out_valid),  32'd0);
    check({tag, " out_result"}, out_result,      32'd0);
    check({tag, " busy"},       32'(busy),       32'd0);
  endtask

  // expected per-cycle tables for the back-to-back and stall sequences
  logic [11:0] b2b_ready = 12'b1111_1110_0111; // bit c = in_ready in cycle c
  logic [11:0] b2b_valid = 12'b0100_1001_0000; // cycles 4, 7, 10
  logic [31:0] b2b_res [3] = '{32'd6, 32'd20, 32'd0};
  logic [31:0] b2b_a   [3] = '{32'd2, 32'd4, 32'h10000};
  logic [31:0] b2b_b   [3] = '{32'd3, 32'd5, 32'h10000};
  logic [31:0] stl_a   [3] = '{32'd11, 32'd3, 32'd5};
  logic [31:0] stl_b   [3] = '{32'd2, 32'd3, 32'd6};

  initial begin
    int zlat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");

    // single op 7 * -3, S=2
    in_valid = 1'b1; in_a = 32'd7; in_b = 32'hFFFF_FFFD;
    step();
    in_valid = 1'b0;
    check("single c1 busy",   32'(busy),   32'd1);
    check("single c1 mul_en", 32'(mul_en), 32'd0);
    step();
    check("single c2 mul_en", 32'(mul_en), 32'd1);
    check("single c2 mul_a",  mul_a,       32'd7);
    check("single c2 mul_b",  mul_b,       32'hFFFF_FFFD);
    check("single c2 valid",  32'(out_valid), 32'd0);
    step();
    check("single c3 mul_en", 32'(mul_en), 32'd1);
    check("single c3 valid",  32'(out_valid), 32'd0);
    step();
    check("single c4 mul_en", 32'(mul_en), 32'd0);
    check("single c4 valid",  32'(out_valid), 32'd1);
    check("single c4 result", out_result,  32'hFFFF_FFEB);
    step();
    check("single c5 valid",  32'(out_valid), 32'd0);
    check("single c5 busy",   32'(busy),   32'd0);
    check("single c5 mul_a hold", mul_a,   32'd7);
    step();

    // three pairs back-to-back, out_ready high
    for (int c = 0; c < 12; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; in_a = b2b_a[c]; in_b = b2b_b[c];
      end else begin
        in_valid = 1'b0;
      end
      check($sformatf("b2b c%0d in_ready", c),  32'(in_ready),  32'(b2b_ready[c]));
      check($sformatf("b2b c%0d out_valid", c), 32'(out_valid), 32'(b2b_valid[c]));
      if (c == 4)  check("b2b result0", out_result, b2b_res[0]);
      if (c == 7)  check("b2b result1", out_result, b2b_res[1]);
      if (c == 10) check("b2b result2", out_result, b2b_res[2]);
      step();
    end
    check("b2b idle busy", 32'(busy), 32'd0);

    // stall: out_ready low from cycle 4 through 8
    out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; in_a = stl_a[c]; in_b = stl_b[c];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (c >= 9);
      if (c >= 3 && c <= 8) check($sformatf("stall c%0d in_ready", c), 32'(in_ready), 32'd0);
      if (c >= 4 && c <= 9) begin
        check($sformatf("stall c%0d valid", c),  32'(out_valid), 32'd1);
        check($sformatf("stall c%0d result", c), out_result,     32'd22);
      end
      if (c == 10 || c == 11 || c == 13 || c == 14)
        check($sformatf("stall c%0d valid low", c), 32'(out_valid), 32'd0);
      if (c == 12) begin
        check("stall second valid",  32'(out_valid), 32'd1);
        check("stall second result", out_result,     32'd9);
      end
      if (c == 15) begin
        check("stall third valid",  32'(out_valid), 32'd1);
        check("stall third result", out_result,     32'd30);
      end
      step();
    end
    check("stall idle busy", 32'(busy), 32'd0);
    out_ready = 1'b1;

    // reset during SETTLE with a second pair queued
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd100;
    step();
    in_a = 32'd8; in_b = 32'd8;
    step();
    in_valid = 1'b0;
    check("rst pre mul_en", 32'(mul_en), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst mid");
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rst after c%0d valid", c), 32'(out_valid), 32'd0);
      check($sformatf("rst after c%0d mul_en", c), 32'(mul_en),  32'd0);
      step();
    end

    // zero operand
`ifdef MUL_ZERO_BYPASS_EN
    zlat = 2;
`else
    zlat = 4;
`endif
    in_valid = 1'b1; in_a = 32'd0; in_b = 32'd12345;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) in_valid = 1'b0;
      check($sformatf("zero c%0d valid", c), 32'(out_valid), 32'(c == zlat));
`ifdef MUL_ZERO_BYPASS_EN
      check($sformatf("zero c%0d mul_en", c), 32'(mul_en), 32'd0);
`else
      check($sformatf("zero c%0d mul_en", c), 32'(mul_en), 32'(c == 2 || c == 3));
`endif
      if (c == zlat) check("zero result", out_result, 32'd0);
      step();
    end
    check("zero idle busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_issue_stage.md
# mul_issue_stage

Registered issue and capture stage wrapped around the combinational Booth multiplier (`b_mul`) in the 32-bit ALU. It buffers incoming operand pairs in a small FIFO and drives registered operands and `en` into the multiplier. It holds those inputs stable for a fixed multicycle settle window, then captures the 32-bit product and presents it downstream with a valid/ready handshake. This lets the multiplier's deep combinational path be timed as a multicycle path instead of a single-cycle one.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: number of cycles `mul_en` is held high with stable operands before the product is captured. Legal range is 1 or more.
- `DEPTH`, default 2: operand FIFO depth. Must be a power of two, 2 or more.

Ports (clock is `clk`; reset is `rst`, synchronous and active-high):
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept an operand pair.
- `in_a` in 32: multiplicand.
- `in_b` in 32: multiplier.
- `mul_a` out 32: registered operand to `b_mul.a`.
- `mul_b` out 32: registered operand to `b_mul.b`.
- `mul_en` out 1: registered enable to `b_mul.en`.
- `mul_result` in 32: product from `b_mul.result`.
- `out_valid` out 1: captured product valid.
- `out_ready` in 1: downstream accepts the product.
- `out_result` out 32: captured product, low 32 bits.
- `busy` out 1: high when the FIFO is non-empty or the FSM is not IDLE.

## Operation
- FIFO push when `in_valid && in_ready`, with `in_ready = !full`. There is no fall-through: a push is visible to the FSM the next cycle. Pop is performed only by the FSM.
- FSM states and transitions:
  - IDLE, FIFO non-empty: pop head into `mul_a`/`mul_b`, set `mul_en`=1, load counter = `SETTLE_CYCLES`, go to SETTLE.
  - SETTLE: decrement the counter each cycle. On the cycle the counter equals 1, register `out_result <= mul_result`, set `out_valid`=1 and `mul_en`=0, go to HOLD.
  - HOLD, `out_ready`=1: clear `out_valid`. If the FIFO is non-empty, pop and load the next pair back-to-back (same action as IDLE) and go to SETTLE. Otherwise go to IDLE.
  - HOLD, `out_ready`=0: `out_valid` and `out_result` stay stable.
- `mul_a`/`mul_b` hold their last value when not in SETTLE. Only `mul_en` gates the multiplier.
- Arithmetic belongs to `b_mul`: the two's-complement low 32 bits of a*b. This stage never alters data.
- Full FIFO with a simultaneous pop: `in_ready` stays low that cycle and rises the next cycle.
- Reset mid-operation: FIFO is flushed, FSM returns to IDLE, and any in-flight product is discarded.

## Timing
- Reset values: `in_ready`=1, `mul_a`=0, `mul_b`=0, `mul_en`=0, `out_valid`=0, `out_result`=0, `busy`=0, FSM=IDLE, FIFO empty.
- Push accepted in cycle 0, pop in cycle 1, `mul_en` high in cycles 2 through 1+S, capture at the end of cycle 1+S, `out_valid` high from cycle 2+S. S is `SETTLE_CYCLES`.
- Latency from accept to `out_valid` is S+2 cycles: 4 with the default.
- Back-to-back throughput with `out_ready` held high: one result every S+1 cycles.
- `mul_en` rises in the cycle after the operand registers load, so operands are stable for the full window. The multicycle constraint on the multiplier path is S cycles.

## Configuration
- `MUL_ZERO_BYPASS_EN` defined: on pop, if `in_a`==0 or `in_b`==0, SETTLE is skipped. The pair is consumed, `out_result`=0 is registered, `out_valid` rises the next cycle (latency 2), and `mul_en` stays 0.
- `MUL_ZERO_BYPASS_EN` undefined: every pair takes the full S+2 latency.

## Structure
- Shared package `mul_stage_pkg`:
  - `MUL_W` = 32.
  - FSM state enum (IDLE, SETTLE, HOLD).
  - Counter width function `$clog2(SETTLE_CYCLES+1)`.
- One sub-module, `mul_op_fifo`: synchronous DEPTH x 64-bit FIFO with push, pop, full and empty, and wrap-around pointers carrying an extra bit.
- The FSM, counter and capture registers live in `mul_issue_stage`, which instantiates `mul_op_fifo` and connects to an external `b_mul`.

## Test plan
- Single op with a=7, b=-3 and S=2: `mul_en` high for exactly 2 cycles, `out_valid` at cycle 4, `out_result`=0xFFFFFFEB.
- Three pairs pushed back-to-back, (2,3), (4,5), (0x10000,0x10000), with `out_ready`=1: results 6, 20, 0 at spacing S+1; `in_ready` drops while the FIFO is full.
- Stall with `out_ready`=0 for 5 cycles: `out_result` stable; FIFO fills to 2 and `in_ready`=0; no product lost or reordered after release.
- `rst` asserted during SETTLE: all outputs return to reset values the next cycle; the pending product never appears.
- With `MUL_ZERO_BYPASS_EN`, a=0, b=12345: `out_valid` at cycle 2, result 0, `mul_en` never high. Without the macro: cycle 4, result 0.
